// File: rtl/number_edit_ctrl.sv
// number_edit_ctrl: front-panel nibble editor for the 16-bit display value.
// Debounced buttons queue edits that share one round-robin 4-bit add/sub stage.
module number_edit_ctrl #(
    parameter int unsigned DB_CNT   = 1_000_000,
    parameter logic [15:0] INIT_NUM = 16'hABCD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic [3:0]  sw,
    output logic [15:0] num,
    output logic        busy,
    output logic [1:0]  sel,
    output logic        upd
);

    localparam int unsigned CW =
        (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        CW'(DB_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    logic [3:0]    btn_s1_q, btn_s1_d;
    logic [3:0]    btn_s2_q, btn_s2_d;
    logic [3:0]    sw_s1_q, sw_s1_d;
    logic [3:0]    sw_s2_q, sw_s2_d;

    logic [3:0]    stable_q, stable_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    rise;

    logic [3:0]    pending_q, pending_d;
    logic [3:0]    clr;

    logic [1:0]    ptr_q, ptr_d;
    logic          win_vld;
    logic [1:0]    win_idx;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    opa_q, opa_d;
    logic          dir_q, dir_d;
    logic [15:0]   num_q, num_d;
    logic          upd_q, upd_d;
    logic [3:0]    res;

    // Two-stage synchronisers for the raw buttons and switches.
    always_comb begin
        btn_s1_d = btn;
        btn_s2_d = btn_s1_q;
        sw_s1_d  = sw;
        sw_s2_d  = sw_s1_q;
    end

    // Debounce: adopt a new level only after it held for DB_CNT cycles.
    always_comb begin
        stable_d = stable_q;
        rise     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (btn_s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = btn_s2_q[i];
                cnt_d[i]    = '0;
                rise[i]     = btn_s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Round-robin winner: first pending index at or above ptr, mod 4.
    always_comb begin
        logic [1:0] idx;
        win_vld = 1'b0;
        win_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!win_vld && pending_q[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Shared nibble add/subtract stage, modulo 16.
    always_comb begin
        if (dir_q) begin
            res = opa_q - 4'd1;
        end else begin
            res = opa_q + 4'd1;
        end
    end

    // Edit FSM: grant in IDLE, fetch operand in READ, commit in WRITE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        opa_d   = opa_q;
        dir_d   = dir_q;
        num_d   = num_q;
        upd_d   = 1'b0;
        clr     = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    clr[win_idx] = 1'b1;
                    sel_d        = win_idx;
                    ptr_d        = win_idx + 2'd1;
                    state_d      = READ;
                end
            end
            READ: begin
                unique case (sel_q)
                    2'd0: opa_d = num_q[3:0];
                    2'd1: opa_d = num_q[7:4];
                    2'd2: opa_d = num_q[11:8];
                    2'd3: opa_d = num_q[15:12];
                endcase
                dir_d   = sw_s2_q[sel_q];
                state_d = WRITE;
            end
            WRITE: begin
                unique case (sel_q)
                    2'd0: num_d[3:0]   = res;
                    2'd1: num_d[7:4]   = res;
                    2'd2: num_d[11:8]  = res;
                    2'd3: num_d[15:12] = res;
                endcase
                upd_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request queue: a new press wins over a same-cycle grant clear.
    always_comb begin
        pending_d = (pending_q & ~clr) | rise;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q  <= 4'b0000;
            btn_s2_q  <= 4'b0000;
            sw_s1_q   <= 4'b0000;
            sw_s2_q   <= 4'b0000;
            stable_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pending_q <= 4'b0000;
            ptr_q     <= 2'd0;
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            opa_q     <= 4'd0;
            dir_q     <= 1'b0;
            num_q     <= INIT_NUM;
            upd_q     <= 1'b0;
        end else begin
            btn_s1_q  <= btn_s1_d;
            btn_s2_q  <= btn_s2_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            stable_q  <= stable_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            opa_q     <= opa_d;
            dir_q     <= dir_d;
            num_q     <= num_d;
            upd_q     <= upd_d;
        end
    end

    assign num  = num_q;
    assign sel  = sel_q;
    assign upd  = upd_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_number_edit_ctrl.sv
// tb_number_edit_ctrl: scoreboard bench for the nibble editor.
// Expected edits are queued at press time and matched on each upd pulse.
module tb_number_edit_ctrl;

    localparam int DB = 4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] num;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic [3:0]  sw;
    logic [15:0] num;
    logic        busy;
    logic [1:0]  sel;
    logic        upd;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          gaps_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          upd_seen = 0;
    int          cyc      = 0;
    int          last_upd = 0;
    logic [15:0] model_num;

    number_edit_ctrl #(
        .DB_CNT  (DB),
        .INIT_NUM(16'hABCD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (btn),
        .sw  (sw),
        .num (num),
        .busy(busy),
        .sel (sel),
        .upd (upd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard: every upd pulse must match the oldest queued edit.
    always @(negedge clk) begin
        if (rst === 1'b0 && upd === 1'b1) begin
            upd_seen++;
            gaps_q.push_back(cyc - last_upd);
            last_upd = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: num=%h sel=%0d, no edit queued",
                         num, sel);
            end else begin
                mon_e = exp_q.pop_front();
                if (num !== mon_e.num || sel !== mon_e.sel) begin
                    errors++;
                    $display("FAIL edit: num=%h sel=%0d, expected num=%h sel=%0d",
                             num, sel, mon_e.num, mon_e.sel);
                end
            end
        end
    end

    task automatic expect_edit(input int i, input logic d);
        logic [3:0] n;
        n = model_num[4*i +: 4];
        n = d ? n - 4'd1 : n + 4'd1;
        model_num[4*i +: 4] = n;
        exp_q.push_back('{sel: 2'(i), num: model_num});
    endtask

    task automatic wait_upd(input int target, input int budget,
                            input string name);
        int n;
        n = 0;
        while (upd_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (upd_seen < target) begin
            errors++;
            $display("FAIL %s: timeout, upd count %0d, expected %0d",
                     name, upd_seen, target);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        btn = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_num = 16'hABCD;
    endtask

    task automatic press(input int i, input logic d, input string name);
        int t;
        expect_edit(i, d);
        @(posedge clk);
        #1;
        sw[i]  = d;
        btn[i] = 1'b1;
        t = upd_seen + 1;
        wait_upd(t, 40, name);
        @(posedge clk);
        #1;
        btn[i] = 1'b0;
        repeat (DB + 6) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 4'b0000;
        sw  = 4'b0000;
        model_num = 16'hABCD;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 5;
        if (num !== 16'hABCD) begin
            errors++;
            $display("FAIL reset_num: got %h, expected abcd", num);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        if (upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_upd: got %b, expected 0", upd);
        end
        if (sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_sel: got %0d, expected 0", sel);
        end
        if (dut.pending_q !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pending: got %b, expected 0000",
                     dut.pending_q);
        end
    endtask

    task automatic test_bounce_inc();
        int base;
        int n;
        base = upd_seen;
        expect_edit(0, 1'b0);
        sw = 4'b0000;
        @(posedge clk);
        #1 btn[0] = 1'b1;
        #3 btn[0] = 1'b0;
        #5 btn[0] = 1'b1;
        #4 btn[0] = 1'b0;
        #4 btn[0] = 1'b1;
        n = 0;
        while (dut.pending_q[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.pending_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_pending: timeout, pending=%b", dut.pending_q);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || sel !== 2'd0) begin
            errors++;
            $display("FAIL grant_t1: busy=%b sel=%0d, expected busy=1 sel=0",
                     busy, sel);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || upd !== 1'b0) begin
            errors++;
            $display("FAIL write_t2: busy=%b upd=%b, expected 1 0", busy, upd);
        end
        @(negedge clk);
        checks++;
        if (upd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL upd_t3: upd=%b busy=%b, expected 1 0", upd, busy);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (upd_seen !== base + 1 || num !== 16'hABCE) begin
            errors++;
            $display("FAIL bounce_hold: %0d upds num=%h, expected 1 abce",
                     upd_seen - base, num);
        end
        btn[0] = 1'b0;
        repeat (DB + 10) @(posedge clk);
        #1;
        checks++;
        if (upd_seen !== base + 1) begin
            errors++;
            $display("FAIL release_ignored: %0d upds, expected 1",
                     upd_seen - base);
        end
    endtask

    task automatic test_wrap();
        press(3, 1'b0, "wrap_n3_a");
        press(3, 1'b0, "wrap_n3_b");
        press(0, 1'b0, "wrap_n0_f");
        press(0, 1'b0, "wrap_n0_0");
        checks++;
        if (num !== 16'hCBC0) begin
            errors++;
            $display("FAIL inc_wrap: got %h, expected cbc0", num);
        end
    endtask

    task automatic test_dec_wrap();
        for (int k = 0; k < 12; k++) begin
            press(1, 1'b1, "dec_to_zero");
        end
        checks++;
        if (num[7:4] !== 4'h0) begin
            errors++;
            $display("FAIL dec_zero: nibble1=%h, expected 0", num[7:4]);
        end
        press(1, 1'b1, "dec_wrap");
        checks++;
        if (num !== 16'hCBF0) begin
            errors++;
            $display("FAIL dec_wrap: got %h, expected cbf0", num);
        end
    endtask

    task automatic test_simultaneous();
        int base;
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            expect_edit(i, 1'b0);
        end
        base = upd_seen;
        gaps_q.delete();
        sw = 4'b0000;
        @(posedge clk);
        #1 btn = 4'b1111;
        n = 0;
        while (dut.pending_q === 4'b0000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.pending_q !== 4'b1111) begin
            errors++;
            $display("FAIL sim_pending: got %b, expected 1111", dut.pending_q);
        end
        wait_upd(base + 4, 40, "sim_edits");
        checks++;
        if (gaps_q.size() != 4) begin
            errors++;
            $display("FAIL sim_count: got %0d upds, expected 4", gaps_q.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (gaps_q[k] != 3) begin
                    errors++;
                    $display("FAIL sim_gap: gap %0d is %0d cycles, expected 3",
                             k, gaps_q[k]);
                end
            end
        end
        @(posedge clk);
        #1 btn = 4'b0000;
        repeat (DB + 6) @(posedge clk);
        #1;
        checks++;
        if (num !== 16'hBCDE) begin
            errors++;
            $display("FAIL sim_num: got %h, expected bcde", num);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        base = upd_seen;
        sw = 4'b0000;
        @(posedge clk);
        #1 btn[2] = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_read: timeout waiting for READ");
        end
        rst = 1'b1;
        btn = 4'b0000;
        #1;
        checks++;
        if (num !== 16'hABCD || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: num=%h busy=%b, expected abcd 0",
                     num, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_num = 16'hABCD;
        repeat (DB + 6) @(posedge clk);
        #1;
        checks++;
        if (upd_seen !== base || num !== 16'hABCD) begin
            errors++;
            $display("FAIL mid_dropped: %0d upds num=%h, expected 0 abcd",
                     upd_seen - base, num);
        end
        press(2, 1'b0, "mid_after");
        checks++;
        if (num !== 16'hACCD) begin
            errors++;
            $display("FAIL mid_after_num: got %h, expected accd", num);
        end
    endtask

    initial begin
        test_reset();
        test_bounce_inc();
        test_wrap();
        test_dec_wrap();
        test_simultaneous();
        test_reset_mid();
        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d edits never seen, expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
